// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types and helpers for the OBI memory arbiter: requester indices,
// source-ID type and the round-robin selection function.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [SRC_W-1:0] src_id_t;

  localparam src_id_t REQ_INSTR = src_id_t'(0);
  localparam src_id_t REQ_DATA  = src_id_t'(1);
  localparam src_id_t REQ_VLSU  = src_id_t'(2);

  // First requester set, starting just after 'last' and wrapping; REQ_INSTR when idle.
  function automatic src_id_t rr_pick(input logic [NUM_REQ-1:0] req, input src_id_t last);
    src_id_t     pick;
    logic        found;
    int unsigned idx;
    pick  = REQ_INSTR;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = src_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// OBI-style memory port: the arbiter is the master, the shared memory the slave.
interface obi_mem_arbiter_if #(
  parameter int unsigned MEM_W = 32
);

  logic               req;
  logic               gnt;
  logic [31:0]        addr;
  logic               we;
  logic [MEM_W/8-1:0] be;
  logic [MEM_W-1:0]   wdata;
  logic               rvalid;
  logic [MEM_W-1:0]   rdata;
  logic               err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_mem_arbiter_src_fifo.sv
// In-order FIFO of source IDs for in-flight memory transactions. A push is
// accepted while full when a pop happens in the same cycle.
module mem_arb_src_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  src_id_t                data_i,
  input  logic                   pop_i,
  output src_id_t                data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  src_id_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Occupancy next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= REQ_INSTR;
      end
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between instruction fetch,
// data and vector LSU; in-order responses are routed back via a source-ID FIFO.
module obi_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  input  logic [NUM_REQ-1:0][31:0]            addr_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ-1:0][MEM_W/8-1:0]     be_i,
  input  logic [NUM_REQ-1:0][MEM_W-1:0]       wdata_i,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [NUM_REQ-1:0][MEM_W-1:0]       rdata_o,
  output logic [NUM_REQ-1:0]                  err_o,
  obi_mem_arbiter_if.master                   mem,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                protocol_err_o
);

  src_id_t last_q;
  src_id_t last_d;
  src_id_t sel_s;
  src_id_t head_s;
  logic    any_req_s;
  logic    can_issue_s;
  logic    xfer_s;
  logic    pop_s;
  logic    full_s;
  logic    empty_s;
  logic    perr_q;
  logic    perr_d;

  mem_arb_src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (xfer_s),
    .data_i  (sel_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (outstanding_o)
  );

  // Request path: pick a requester and drive the memory port with its fields.
  always_comb begin
    any_req_s   = |req_i;
    sel_s       = any_req_s ? rr_pick(req_i, last_q) : REQ_INSTR;
    can_issue_s = ~full_s | (full_s & mem.rvalid);
    mem.req     = any_req_s & can_issue_s;
    mem.addr    = addr_i[sel_s];
    mem.we      = we_i[sel_s];
    mem.be      = be_i[sel_s];
    mem.wdata   = wdata_i[sel_s];
    xfer_s      = mem.req & mem.gnt;
    gnt_o       = {NUM_REQ{1'b0}};
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      gnt_o[i] = xfer_s & (sel_s == src_id_t'(i));
    end
  end

  // Response path: the FIFO head names the requester owning this response.
  always_comb begin
    pop_s    = mem.rvalid & ~empty_s;
    rvalid_o = {NUM_REQ{1'b0}};
    err_o    = {NUM_REQ{1'b0}};
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rvalid_o[i] = pop_s & (head_s == src_id_t'(i));
      err_o[i]    = pop_s & (head_s == src_id_t'(i)) & mem.err;
      rdata_o[i]  = mem.rdata;
    end
  end

  // Pointer moves only on a transfer; a response with nothing in flight is sticky.
  always_comb begin
    last_d = xfer_s ? sel_s : last_q;
    perr_d = perr_q | (mem.rvalid & empty_s);
  end

  // Arbitration pointer and protocol error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= src_id_t'(NUM_REQ - 1);
      perr_q <= 1'b0;
    end else begin
      last_q <= last_d;
      perr_q <= perr_d;
    end
  end

  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_obi_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req;
  logic [2:0]       we;
  logic [2:0][31:0] addr;
  logic [2:0][3:0]  be;
  logic [2:0][31:0] wdata;
  logic [2:0]       gnt_o;
  logic [2:0]       rvalid_o;
  logic [2:0]       err_o;
  logic [2:0][31:0] rdata_o;
  logic [2:0]       outst;
  logic             perr;

  int errors = 0;
  int checks = 0;

  // reference model state
  int q_m[$];
  int last_m;
  bit perr_m;
  int e_sel;
  bit e_mreq, e_xfer, e_pop, e_spur;
  logic [2:0] e_gnt, e_rv, e_err;

  obi_mem_arbiter_if #(.MEM_W(32)) mem_if ();

  obi_mem_arbiter #(.MEM_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .gnt_o          (gnt_o),
    .addr_i         (addr),
    .we_i           (we),
    .be_i           (be),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .mem            (mem_if),
    .outstanding_o  (outst),
    .protocol_err_o (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    q_m.delete();
    last_m = 2;
    perr_m = 1'b0;
  endfunction

  function automatic void model_eval();
    bit full_m;
    bit found;
    full_m = (q_m.size() == 4);
    found  = 1'b0;
    e_sel  = 0;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last_m + k) % 3;
      if (!found && req[idx]) begin
        e_sel = idx;
        found = 1'b1;
      end
    end
    e_mreq = (req != 3'b000) && (!full_m || mem_if.rvalid);
    e_xfer = e_mreq && mem_if.gnt;
    e_gnt  = e_xfer ? 3'(1 << e_sel) : 3'b000;
    e_pop  = mem_if.rvalid && (q_m.size() > 0);
    e_spur = mem_if.rvalid && (q_m.size() == 0);
    e_rv   = e_pop ? 3'(1 << q_m[0]) : 3'b000;
    e_err  = (e_pop && mem_if.err) ? e_rv : 3'b000;
  endfunction

  function automatic void model_commit();
    if (e_pop) void'(q_m.pop_front());
    if (e_xfer) begin
      q_m.push_back(e_sel);
      last_m = e_sel;
    end
    if (e_spur) perr_m = 1'b1;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle_inputs();
    req = 3'b000; we = 3'b000; addr = '0; be = '0; wdata = '0;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0; mem_if.err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (outst !== 3'd0) begin errors++; $display("FAIL rst_outst: got %0d want 0", outst); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", perr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b000 || rvalid_o !== 3'b000 || err_o !== 3'b000) begin
      errors++; $display("FAIL rst_outputs: gnt=%b rvalid=%b err=%b want 000", gnt_o, rvalid_o, err_o);
    end
    checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL rst_memreq: got %b want 0", mem_if.req); end
  endtask

  task automatic test_single();
    req = 3'b001; addr[0] = 32'h80; mem_if.gnt = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt_o); end
    checks++; if (mem_if.addr !== 32'h80) begin errors++; $display("FAIL single_addr: got %h want 80", mem_if.addr); end
    tick();
    req = 3'b000; mem_if.gnt = 1'b0;
    #1;
    checks++; if (outst !== 3'd1) begin errors++; $display("FAIL single_outst1: got %0d want 1", outst); end
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'h13;
    #1;
    checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL single_rvalid: got %b want 001", rvalid_o); end
    checks++; if (rdata_o[0] !== 32'h13 || rdata_o[2] !== 32'h13) begin
      errors++; $display("FAIL single_rdata: got %h/%h want 13", rdata_o[0], rdata_o[2]);
    end
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    checks++; if (outst !== 3'd0) begin errors++; $display("FAIL single_outst0: got %0d want 0", outst); end
  endtask

  task automatic test_rr_fill_and_full_pushpop();
    logic [2:0] exp_g [5];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001; exp_g[4] = 3'b000;
    do_reset();
    req = 3'b111; mem_if.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (gnt_o !== exp_g[k]) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_o, exp_g[k]); end
      if (k < 4) tick();
    end
    checks++; if (mem_if.req !== 1'b0 || outst !== 3'd4) begin
      errors++; $display("FAIL full_stall: memreq=%b outst=%0d want 0/4", mem_if.req, outst);
    end
    mem_if.rvalid = 1'b1; mem_if.rdata = $urandom;
    #1;
    checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL full_pp_gnt: got %b want 010", gnt_o); end
    checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL full_pp_rvalid: got %b want 001", rvalid_o); end
    tick();
    mem_if.rvalid = 1'b0; req = 3'b000;
    #1;
    checks++; if (outst !== 3'd4) begin errors++; $display("FAIL full_pp_outst: got %0d want 4", outst); end
  endtask

  task automatic test_err_order();
    logic [2:0] exp_rv [3];
    logic [2:0] exp_er [3];
    exp_rv[0] = 3'b010; exp_rv[1] = 3'b001; exp_rv[2] = 3'b100;
    exp_er[0] = 3'b000; exp_er[1] = 3'b001; exp_er[2] = 3'b000;
    do_reset();
    mem_if.gnt = 1'b1;
    req = 3'b010; tick();
    req = 3'b001; tick();
    req = 3'b100; tick();
    req = 3'b000; mem_if.gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_if.rvalid = 1'b1; mem_if.err = (k == 1); mem_if.rdata = $urandom;
      #1;
      checks++; if (rvalid_o !== exp_rv[k]) begin errors++; $display("FAIL order_rvalid%0d: got %b want %b", k, rvalid_o, exp_rv[k]); end
      checks++; if (err_o !== exp_er[k]) begin errors++; $display("FAIL order_err%0d: got %b want %b", k, err_o, exp_er[k]); end
      tick();
    end
    mem_if.rvalid = 1'b0; mem_if.err = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    req = 3'b010; addr[1] = a; mem_if.gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt_o !== 3'b000 || mem_if.addr !== a) begin
        errors++; $display("FAIL stall%0d: gnt=%b addr=%h want 000/%h", k, gnt_o, mem_if.addr, a);
      end
      tick();
    end
    mem_if.gnt = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL stall_gnt: got %b want 010", gnt_o); end
    tick();
    req = 3'b110;
    #1;
    checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL stall_ptr: got %b want 100", gnt_o); end
    tick();
    req = 3'b000; mem_if.gnt = 1'b0;
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    mem_if.rvalid = 1'b1;
    #1;
    checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL spur_rvalid: got %b want 000", rvalid_o); end
    tick();
    mem_if.rvalid = 1'b0;
    tick();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL spur_perr_sticky: got %b want 1", perr); end
    req = 3'b001; mem_if.gnt = 1'b1;
    tick(); tick();
    req = 3'b000; mem_if.gnt = 1'b0;
    #1;
    checks++; if (outst !== 3'd2) begin errors++; $display("FAIL midrst_pre: got %0d want 2", outst); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (outst !== 3'd0 || perr !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: outst=%0d perr=%b want 0/0", outst, perr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_if.rvalid = 1'b1;
    #1;
    checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL postrst_rvalid: got %b want 000", rvalid_o); end
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL postrst_perr: got %b want 1", perr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req           = 3'($urandom_range(0, 7));
      we            = 3'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++) begin
        addr[r]  = $urandom;
        wdata[r] = $urandom;
        be[r]    = 4'($urandom_range(0, 15));
      end
      mem_if.gnt    = ($urandom_range(0, 3) != 0);
      mem_if.rvalid = (q_m.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_if.err    = ($urandom_range(0, 3) == 0);
      mem_if.rdata  = $urandom;
      #1;
      model_eval();
      checks++; if (gnt_o !== e_gnt || mem_if.req !== e_mreq) begin
        errors++; $display("FAIL rnd_gnt@%0d: gnt=%b req=%b want %b/%b", n, gnt_o, mem_if.req, e_gnt, e_mreq);
      end
      checks++; if (mem_if.addr !== addr[e_sel] || mem_if.wdata !== wdata[e_sel] ||
                    mem_if.we !== we[e_sel] || mem_if.be !== be[e_sel]) begin
        errors++; $display("FAIL rnd_mux@%0d: addr=%h want %h (sel %0d)", n, mem_if.addr, addr[e_sel], e_sel);
      end
      checks++; if (rvalid_o !== e_rv || err_o !== e_err) begin
        errors++; $display("FAIL rnd_resp@%0d: rvalid=%b err=%b want %b/%b", n, rvalid_o, err_o, e_rv, e_err);
      end
      checks++; if (rdata_o[1] !== mem_if.rdata) begin
        errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, rdata_o[1], mem_if.rdata);
      end
      tick();
      checks++; if (outst !== 3'(q_m.size()) || perr !== perr_m) begin
        errors++; $display("FAIL rnd_state@%0d: outst=%0d perr=%b want %0d/%b", n, outst, perr, q_m.size(), perr_m);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fill_and_full_pushpop();
    test_err_order();
    test_stall();
    test_spurious_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
